// File: rtl/int_reg_read_stage_pkg.sv
// Shared types for the integer operand-read stage: register index, carried payload, zero index.
// Also holds the per-source operand select used by the stage.
package int_reg_read_stage_pkg;

   localparam int XLEN          = 32;
   localparam int REG_ADDR_W    = 5;
   localparam int REG_FILE_SIZE = 2**REG_ADDR_W;
   localparam int PAYLOAD_W     = 64;

   typedef logic [XLEN-1:0]       word_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t ZERO_REG = '0;

   typedef struct packed {
      logic [PAYLOAD_W-1:0] payload;
      reg_addr_t            rd;
      logic                 rd_en;
   } read_stage_payload_t;

   // x0 beats the bypass, the bypass beats the register file.
   function automatic word_t sel_operand(input reg_addr_t rs, input logic byp,
                                         input word_t wb_val, input word_t rf_val);
      if (rs == ZERO_REG) return '0;
      if (byp)            return wb_val;
      return rf_val;
   endfunction

endpackage

// File: rtl/int_reg_scoreboard.sv
// Per-register busy vector: set on issue, cleared by writeback or by flushing the held instruction.
// Next-state only; a set and a clear on the same register in one cycle leaves it busy.
// Lookups are combinational off the registered vector.
module int_reg_scoreboard
   import int_reg_read_stage_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      set_en,
   input  reg_addr_t set_addr,
   input  logic      clr_en,
   input  reg_addr_t clr_addr,
   input  logic      flush_clr_en,
   input  reg_addr_t flush_clr_addr,
   input  reg_addr_t look_addr1,
   input  reg_addr_t look_addr2,
   input  reg_addr_t look_addr3,
   output logic      look_busy1,
   output logic      look_busy2,
   output logic      look_busy3
);

   logic [REG_FILE_SIZE-1:0] busy;
   logic [REG_FILE_SIZE-1:0] busy_nxt;

   always_comb begin
      busy_nxt = busy;
      if (clr_en)       busy_nxt[clr_addr]       = 1'b0;
      if (flush_clr_en) busy_nxt[flush_clr_addr] = 1'b0;
      if (set_en)       busy_nxt[set_addr]       = 1'b1;
      busy_nxt[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy <= '0;
      else      busy <= busy_nxt;
   end

   assign look_busy1 = busy[look_addr1];
   assign look_busy2 = busy[look_addr2];
   assign look_busy3 = busy[look_addr3];

endmodule

// File: rtl/int_reg_read_stage.sv
// Operand-read stage: register-file read, optional writeback bypass (INT_REG_READ_BYPASS_EN), RAW/WAW stall.
// Latency: 1 cycle accept-to-out_valid. Backpressure: valid/ready; in_ready drops on hazard, flush or full stage.
// Without INT_REG_READ_BYPASS_EN a register written this cycle stalls one more cycle and is read from the file.
module int_reg_read_stage
   import int_reg_read_stage_pkg::*;
#(
   parameter int XLEN       = int_reg_read_stage_pkg::XLEN,
   parameter int REG_ADDR_W = int_reg_read_stage_pkg::REG_ADDR_W,
   parameter int PAYLOAD_W  = int_reg_read_stage_pkg::PAYLOAD_W
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [REG_ADDR_W-1:0] in_rs1,
   input  logic [REG_ADDR_W-1:0] in_rs2,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic                  in_rd_en,
   input  logic [PAYLOAD_W-1:0]  in_payload,
   output logic [REG_ADDR_W-1:0] rf_read_addr1,
   output logic [REG_ADDR_W-1:0] rf_read_addr2,
   input  logic [XLEN-1:0]       rf_read_value1,
   input  logic [XLEN-1:0]       rf_read_value2,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [XLEN-1:0]       wb_value,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_src1,
   output logic [XLEN-1:0]       out_src2,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic                  out_rd_en,
   output logic [PAYLOAD_W-1:0]  out_payload
);

   logic                bypass1, bypass2, wb_hits_rd;
   logic                busy1, busy2, busy_rd;
   logic                hazard, accept;
   logic                out_valid_q;
   read_stage_payload_t out_q;
   word_t               src1_q, src2_q;

   assign rf_read_addr1 = in_rs1;
   assign rf_read_addr2 = in_rs2;

`ifdef INT_REG_READ_BYPASS_EN
   assign bypass1    = wb_valid && (wb_addr == in_rs1) && (in_rs1 != ZERO_REG);
   assign bypass2    = wb_valid && (wb_addr == in_rs2) && (in_rs2 != ZERO_REG);
   assign wb_hits_rd = wb_valid && (wb_addr == in_rd);
`else
   // Forced off: the operand mux folds down to the register-file path.
   assign bypass1    = 1'b0;
   assign bypass2    = 1'b0;
   assign wb_hits_rd = 1'b0;
`endif

   int_reg_scoreboard u_sb (
      .clk            (clk),
      .rst            (rst),
      .set_en         (accept && in_rd_en),
      .set_addr       (in_rd),
      .clr_en         (wb_valid),
      .clr_addr       (wb_addr),
      .flush_clr_en   (flush && out_valid_q && out_q.rd_en && !(wb_valid && wb_addr == out_q.rd)),
      .flush_clr_addr (out_q.rd),
      .look_addr1     (in_rs1),
      .look_addr2     (in_rs2),
      .look_addr3     (in_rd),
      .look_busy1     (busy1),
      .look_busy2     (busy2),
      .look_busy3     (busy_rd)
   );

   assign hazard   = (busy1 && !bypass1) || (busy2 && !bypass2) ||
                     (in_rd_en && busy_rd && !wb_hits_rd);
   assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         src1_q      <= '0;
         src2_q      <= '0;
      end else if (accept) begin
         out_valid_q   <= 1'b1;
         out_q.payload <= in_payload;
         out_q.rd      <= in_rd;
         out_q.rd_en   <= in_rd_en;
         src1_q        <= sel_operand(in_rs1, bypass1, wb_value, rf_read_value1);
         src2_q        <= sel_operand(in_rs2, bypass2, wb_value, rf_read_value2);
      end else if (flush || out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_src1    = src1_q;
   assign out_src2    = src2_q;
   assign out_rd      = out_q.rd;
   assign out_rd_en   = out_q.rd_en;
   assign out_payload = out_q.payload;

endmodule

// File: doc/int_reg_read_stage.md
Name: int_reg_read_stage

Overview:
- Operand-read pipeline stage sitting directly upstream of the integer register file's consumers and downstream of decode.
- Drives the register file's two read addresses and captures the read values into an output pipeline register.
- Applies writeback bypass and a per-register busy scoreboard, stalling decode on RAW/WAW hazards.
- Presents ready/valid operands to execute.

Parameters:
- XLEN, 32, operand width; matches word_t.
- REG_ADDR_W, 5, register index width (REG_FILE_SIZE = 2**REG_ADDR_W).
- PAYLOAD_W, 64, opaque decode payload (pc, opcode fields) carried alongside operands.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage accepts this cycle
- in_rs1, in_rs2  in  REG_ADDR_W  source indices
- in_rd  in  REG_ADDR_W  destination index
- in_rd_en  in  1  instruction writes rd
- in_payload  in  PAYLOAD_W  carried data
- rf_read_addr1, rf_read_addr2  out  REG_ADDR_W  to register file (combinational = in_rs1/in_rs2)
- rf_read_value1, rf_read_value2  in  XLEN  from register file (combinational)
- wb_valid  in  1  writeback this cycle (same bus feeds register file write port)
- wb_addr  in  REG_ADDR_W  writeback index
- wb_value  in  XLEN  writeback data
- flush  in  1  drop instruction held in output register
- out_valid  out  1  operands valid
- out_ready  in  1  execute accepts
- out_src1, out_src2  out  XLEN  resolved operands
- out_rd, out_rd_en, out_payload  out  -  registered copies of the inputs

Behaviour:
- Reset (rst low, async): out_valid=0; out_src1/2, out_rd, out_rd_en, out_payload=0; all busy bits=0.
- Latency: 1 cycle from accept to out_valid.
- busy[r] is set when an instruction with rd_en && rd!=0 is accepted. It is cleared when wb_valid && wb_addr==r.
- Set and clear hitting the same r in the same cycle: set wins.
- busy[0] is always 0.
- hazard = (busy[rs1] && !bypass1) || (busy[rs2] && !bypass2) || (in_rd_en && busy[in_rd] && !(wb_valid && wb_addr==in_rd)).
- bypassN = wb_valid && wb_addr==rsN && rsN!=0.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Accept = in_valid && in_ready. On accept the output register loads and out_valid=1.
- If out_ready && out_valid && !accept, then out_valid goes to 0.
- Operand select, per source, evaluated in priority order:
  - rs==0 gives 0.
  - bypass gives wb_value.
  - Otherwise rf_read_value.
- out_* are held stable while out_valid && !out_ready.
- flush: out_valid goes to 0 next cycle. The busy bit of the held instruction (if out_rd_en && out_rd!=0) is cleared unless wb is writing that same register. No accept occurs that cycle.
- wb_valid with wb_addr==0 or with a non-busy register: no state change and no error.
- Reset asserted mid-stall: everything returns to reset values immediately. Pending busy state is lost by design, because the core resets as a whole.

Optional Feature:
- Macro: INT_REG_READ_BYPASS_EN.
- Defined: writeback bypass as above.
- Undefined: bypassN is forced to 0, and the WAW wb exception is removed. A register being written this cycle stays a hazard. The instruction issues the cycle after, reading the updated register-file value. This costs 1 stall cycle per hit, but there is no XLEN mux.

Decomposition:
- Shared RafiTypes package gets:
  - reg_addr_t (REG_ADDR_W bits)
  - read_stage_payload_t
  - a constant for the hardwired zero index
- One natural sub-module: int_reg_scoreboard. It holds the busy vector with set/clear/flush-clear inputs and exposes a busy lookup for three addresses. The stage instantiates it.

Test Plan:
- Reset, then issue addi x5 with rs1=x0, out_ready=1 → out_valid the next cycle, out_src1=0, busy[5]=1.
- Issue rd=x5, then an instruction with rs1=x5 while wb is idle → in_ready=0 until wb_valid with wb_addr=5, wb_value=0x1234.
  - With BYPASS_EN: it issues that same cycle with out_src1=0x1234.
  - Without BYPASS_EN: it issues one cycle later with out_src1 equal to the register-file value.
- Hold out_ready=0 for 3 cycles with out_valid=1 → out_* stable, in_ready=0. Raise out_ready → drain, and the next instruction is accepted that cycle.
- Accept rd=x7 while wb_valid clears x7 in the same cycle → busy[7] stays 1.
- Hold an instruction with rd=x9 in the output register and pulse flush → out_valid=0, busy[9]=0, and a following read of x9 proceeds without stall.
- Assert rst low asynchronously between clock edges while stalled → out_valid and all busy bits read 0 before the next edge.
